// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: ALU operation codes (same encoding as ALU control)
// and forwarding-mux select values.
package mips_pkg;

    localparam logic [3:0] ALU_SLL = 4'b0000;
    localparam logic [3:0] ALU_SRL = 4'b0001;
    localparam logic [3:0] ALU_SRA = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0011;
    localparam logic [3:0] ALU_SLT = 4'b0100;
    localparam logic [3:0] ALU_AND = 4'b0101;
    localparam logic [3:0] ALU_OR  = 4'b0110;
    localparam logic [3:0] ALU_XOR = 4'b0111;
    localparam logic [3:0] ALU_NOR = 4'b1000;
    localparam logic [3:0] ALU_LUI = 4'b1001;
    localparam logic [3:0] ALU_SUB = 4'b1010;

    localparam logic [1:0] FWD_RF    = 2'b00;
    localparam logic [1:0] FWD_EXMEM = 2'b10;
    localparam logic [1:0] FWD_MEMWB = 2'b01;

endpackage

// File: rtl/forwarding_unit.sv
// RAW forwarding select for both EX operands: the EX/MEM result beats the MEM/WB writeback,
// and register r0 is never forwarded. Loads in EX/MEM are excluded (their data is not ready yet).
module forwarding_unit
    import mips_pkg::*;
#(
    parameter int NB_REG = 5
) (
    input  logic [NB_REG-1:0] rs_addr,
    input  logic [NB_REG-1:0] rt_addr,
    input  logic              exmem_valid,
    input  logic              exmem_regwrite,
    input  logic              exmem_memread,
    input  logic [NB_REG-1:0] exmem_rd,
    input  logic              wb_regwrite,
    input  logic [NB_REG-1:0] wb_rd,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b
);

    logic exmem_live;
    logic wb_live;

    assign exmem_live = exmem_valid && exmem_regwrite && !exmem_memread && (exmem_rd != '0);
    assign wb_live    = wb_regwrite && (wb_rd != '0);

    assign fwd_a = (exmem_live && exmem_rd == rs_addr) ? FWD_EXMEM :
                   (wb_live    && wb_rd    == rs_addr) ? FWD_MEMWB : FWD_RF;
    assign fwd_b = (exmem_live && exmem_rd == rt_addr) ? FWD_EXMEM :
                   (wb_live    && wb_rd    == rt_addr) ? FWD_MEMWB : FWD_RF;

endmodule

// File: rtl/execute_stage.sv
// MIPS EX stage: operand forwarding, ALU, and the EX/MEM pipeline register with stall/flush.
// Define EXECUTE_FORWARDING_EN to enable forwarding; otherwise raw register-file operands are used.
module execute_stage
    import mips_pkg::*;
#(
    parameter int NB_DATA = 32,
    parameter int NB_REG  = 5,
    parameter int NB_CODE = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               stall,
    input  logic               flush,
    input  logic               in_valid,
    input  logic [NB_CODE-1:0] alu_code,
    input  logic [NB_DATA-1:0] rs_data,
    input  logic [NB_DATA-1:0] rt_data,
    input  logic [NB_DATA-1:0] imm_ext,
    input  logic [4:0]         shamt,
    input  logic               alusrc,
    input  logic               shift_src,
    input  logic [NB_REG-1:0]  rs_addr,
    input  logic [NB_REG-1:0]  rt_addr,
    input  logic [NB_REG-1:0]  rd_dest,
    input  logic               regwrite,
    input  logic               memread,
    input  logic               memwrite,
    input  logic               memtoreg,
    input  logic               wb_regwrite,
    input  logic [NB_REG-1:0]  wb_rd,
    input  logic [NB_DATA-1:0] wb_data,
    output logic               out_valid,
    output logic [NB_DATA-1:0] alu_result,
    output logic [NB_DATA-1:0] store_data,
    output logic               zero,
    output logic [NB_REG-1:0]  out_rd,
    output logic               out_regwrite,
    output logic               out_memread,
    output logic               out_memwrite,
    output logic               out_memtoreg
);

    typedef struct packed {
        logic               valid;
        logic [NB_DATA-1:0] result;
        logic [NB_DATA-1:0] store_data;
        logic               zero;
        logic [NB_REG-1:0]  rd;
        logic               regwrite;
        logic               memread;
        logic               memwrite;
        logic               memtoreg;
    } exmem_t;

    exmem_t             exmem_d, exmem_q;
    logic [NB_DATA-1:0] op_a, fwd_rt, op_b, result;
    logic [4:0]         sa;

`ifdef EXECUTE_FORWARDING_EN
    logic [1:0] fwd_a, fwd_b;

    forwarding_unit #(.NB_REG(NB_REG)) u_forwarding_unit (
        .rs_addr        (rs_addr),
        .rt_addr        (rt_addr),
        .exmem_valid    (exmem_q.valid),
        .exmem_regwrite (exmem_q.regwrite),
        .exmem_memread  (exmem_q.memread),
        .exmem_rd       (exmem_q.rd),
        .wb_regwrite    (wb_regwrite),
        .wb_rd          (wb_rd),
        .fwd_a          (fwd_a),
        .fwd_b          (fwd_b)
    );

    // Forwarding from exmem_q means a stalled instruction keeps seeing the held result.
    always_comb begin
        case (fwd_a)
            FWD_EXMEM: op_a = exmem_q.result;
            FWD_MEMWB: op_a = wb_data;
            default:   op_a = rs_data;
        endcase
        case (fwd_b)
            FWD_EXMEM: fwd_rt = exmem_q.result;
            FWD_MEMWB: fwd_rt = wb_data;
            default:   fwd_rt = rt_data;
        endcase
    end
`else
    logic unused_fwd_inputs;

    assign unused_fwd_inputs = ^{wb_regwrite, wb_rd, wb_data, rs_addr, rt_addr};
    assign op_a   = rs_data;
    assign fwd_rt = rt_data;
`endif

    assign op_b = alusrc ? imm_ext : fwd_rt;
    assign sa   = shift_src ? op_a[4:0] : shamt;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        result = '0;
        case (alu_code)
            ALU_SLL: result = op_b << sa;
            ALU_SRL: result = op_b >> sa;
            ALU_SRA: result = $signed(op_b) >>> sa;
            ALU_ADD: result = op_a + op_b;
            ALU_SLT: result = {{(NB_DATA-1){1'b0}}, ($signed(op_a) < $signed(op_b))};
            ALU_AND: result = op_a & op_b;
            ALU_OR:  result = op_a | op_b;
            ALU_XOR: result = op_a ^ op_b;
            ALU_NOR: result = ~(op_a | op_b);
            ALU_LUI: result = {op_b[NB_DATA/2-1:0], {(NB_DATA/2){1'b0}}};
            ALU_SUB: result = op_a - op_b;
            default: result = '0;
        endcase
    end

    // Flush beats stall; reset (in the flop) beats both.
    always_comb begin
        exmem_d = exmem_q;
        if (flush) begin
            exmem_d = '0;
        end else if (!stall) begin
            exmem_d.valid      = in_valid;
            exmem_d.result     = result;
            exmem_d.store_data = fwd_rt;
            exmem_d.zero       = (result == '0);
            exmem_d.rd         = rd_dest;
            exmem_d.regwrite   = in_valid & regwrite;
            exmem_d.memread    = in_valid & memread;
            exmem_d.memwrite   = in_valid & memwrite;
            exmem_d.memtoreg   = in_valid & memtoreg;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            exmem_q <= '0;
        end else begin
            exmem_q <= exmem_d;
        end
    end

    assign out_valid    = exmem_q.valid;
    assign alu_result   = exmem_q.result;
    assign store_data   = exmem_q.store_data;
    assign zero         = exmem_q.zero;
    assign out_rd       = exmem_q.rd;
    assign out_regwrite = exmem_q.regwrite;
    assign out_memread  = exmem_q.memread;
    assign out_memwrite = exmem_q.memwrite;
    assign out_memtoreg = exmem_q.memtoreg;

endmodule

// File: tb/tb_execute_stage.sv
// Scoreboard bench for execute_stage: a reference model predicts each EX/MEM update at the
// rising edge, a monitor compares the registered outputs on the falling edge.
module tb_execute_stage;

`ifdef EXECUTE_FORWARDING_EN
    localparam bit FWD_EN = 1'b1;
`else
    localparam bit FWD_EN = 1'b0;
`endif

    logic        clk;
    logic        reset, stall, flush, in_valid;
    logic [3:0]  alu_code;
    logic [31:0] rs_data, rt_data, imm_ext, wb_data;
    logic [4:0]  shamt, rs_addr, rt_addr, rd_dest, wb_rd;
    logic        alusrc, shift_src, regwrite, memread, memwrite, memtoreg, wb_regwrite;
    logic        out_valid, zero, out_regwrite, out_memread, out_memwrite, out_memtoreg;
    logic [31:0] alu_result, store_data;
    logic [4:0]  out_rd;

    typedef struct packed {
        logic        valid;
        logic [31:0] result;
        logic [31:0] store;
        logic        zero;
        logic [4:0]  rd;
        logic        rw;
        logic        mr;
        logic        mw;
        logic        mt;
    } out_t;

    out_t  exp_q[$];
    string tag_q[$];
    out_t  mdl;
    out_t  dut_out;
    int    checks   = 0;
    int    failures = 0;

    execute_stage dut (
        .clk(clk), .reset(reset), .stall(stall), .flush(flush), .in_valid(in_valid),
        .alu_code(alu_code), .rs_data(rs_data), .rt_data(rt_data), .imm_ext(imm_ext),
        .shamt(shamt), .alusrc(alusrc), .shift_src(shift_src), .rs_addr(rs_addr),
        .rt_addr(rt_addr), .rd_dest(rd_dest), .regwrite(regwrite), .memread(memread),
        .memwrite(memwrite), .memtoreg(memtoreg), .wb_regwrite(wb_regwrite), .wb_rd(wb_rd),
        .wb_data(wb_data), .out_valid(out_valid), .alu_result(alu_result),
        .store_data(store_data), .zero(zero), .out_rd(out_rd), .out_regwrite(out_regwrite),
        .out_memread(out_memread), .out_memwrite(out_memwrite), .out_memtoreg(out_memtoreg)
    );

    assign dut_out = '{valid: out_valid, result: alu_result, store: store_data, zero: zero,
                       rd: out_rd, rw: out_regwrite, mr: out_memread, mw: out_memwrite,
                       mt: out_memtoreg};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input out_t act, input out_t exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got valid=%b res=%h st=%h z=%b rd=%0d ctl=%b%b%b%b, expected valid=%b res=%h st=%h z=%b rd=%0d ctl=%b%b%b%b",
                     name, act.valid, act.result, act.store, act.zero, act.rd,
                     act.rw, act.mr, act.mw, act.mt, exp.valid, exp.result, exp.store,
                     exp.zero, exp.rd, exp.rw, exp.mr, exp.mw, exp.mt);
        end
    endtask

    // ALU behaviour written from the operation table.
    function automatic logic [31:0] alu_ref(input logic [3:0] code, input logic [31:0] a,
                                            input logic [31:0] b, input logic [4:0] sa);
        case (code)
            4'd0:    return b << sa;
            4'd1:    return b >> sa;
            4'd2:    return (b >> sa) | (b[31] ? ~(32'hFFFF_FFFF >> sa) : 32'h0);
            4'd3:    return a + b;
            4'd4:    return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            4'd5:    return a & b;
            4'd6:    return a | b;
            4'd7:    return a ^ b;
            4'd8:    return ~(a | b);
            4'd9:    return b * 32'd65536;
            4'd10:   return a - b;
            default: return 32'd0;
        endcase
    endfunction

    // Operand value seen by EX for register 'addr' given the model's EX/MEM contents.
    function automatic logic [31:0] fwd(input logic [4:0] addr, input logic [31:0] raw);
        if (FWD_EN && mdl.valid && mdl.rw && !mdl.mr && mdl.rd != 0 && mdl.rd == addr)
            return mdl.result;
        if (FWD_EN && wb_regwrite && wb_rd != 0 && wb_rd == addr)
            return wb_data;
        return raw;
    endfunction

    // One clock: the model consumes the currently driven inputs at the edge.
    task automatic step(input string tag);
        out_t        n;
        logic [31:0] a, rt, b;
        logic [4:0]  sa;
        @(posedge clk);
        a  = fwd(rs_addr, rs_data);
        rt = fwd(rt_addr, rt_data);
        b  = alusrc ? imm_ext : rt;
        sa = shift_src ? a[4:0] : shamt;
        if (reset || flush) begin
            n = '0;
        end else if (stall) begin
            n = mdl;
        end else begin
            n.valid  = in_valid;
            n.result = alu_ref(alu_code, a, b, sa);
            n.store  = rt;
            n.zero   = (n.result == 32'd0);
            n.rd     = rd_dest;
            n.rw     = in_valid & regwrite;
            n.mr     = in_valid & memread;
            n.mw     = in_valid & memwrite;
            n.mt     = in_valid & memtoreg;
        end
        mdl = n;
        exp_q.push_back(n);
        tag_q.push_back(tag);
        #1;
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            check(tag_q.pop_front(), dut_out, exp_q.pop_front());
        end
    end

    task automatic randomize_inputs();
        reset       = ($urandom_range(0, 63) == 0);
        flush       = ($urandom_range(0, 15) == 0);
        stall       = ($urandom_range(0, 7) == 0);
        in_valid    = ($urandom_range(0, 7) != 0);
        alu_code    = 4'($urandom_range(0, 15));
        rs_data     = $urandom;
        rt_data     = $urandom;
        imm_ext     = $urandom;
        wb_data     = $urandom;
        shamt       = 5'($urandom);
        rs_addr     = 5'($urandom_range(0, 3));
        rt_addr     = 5'($urandom_range(0, 3));
        rd_dest     = 5'($urandom_range(0, 3));
        wb_rd       = 5'($urandom_range(0, 3));
        alusrc      = 1'($urandom);
        shift_src   = 1'($urandom);
        regwrite    = ($urandom_range(0, 3) != 0);
        memread     = ($urandom_range(0, 3) == 0);
        memwrite    = 1'($urandom);
        memtoreg    = 1'($urandom);
        wb_regwrite = 1'($urandom);
    endtask

    task automatic idle();
        reset = 1'b0; flush = 1'b0; stall = 1'b0; in_valid = 1'b1;
        alusrc = 1'b0; shift_src = 1'b0; shamt = 5'd0; imm_ext = 32'd0;
        regwrite = 1'b0; memread = 1'b0; memwrite = 1'b0; memtoreg = 1'b0;
        wb_regwrite = 1'b0; wb_rd = 5'd0; wb_data = 32'd0; rd_dest = 5'd5;
    endtask

    task automatic set_op(input logic [3:0] code, input logic [4:0] ra, input logic [31:0] da,
                          input logic [4:0] rb, input logic [31:0] db);
        alu_code = code; rs_addr = ra; rs_data = da; rt_addr = rb; rt_data = db;
    endtask

    initial begin
        mdl = '0;
        randomize_inputs();
        reset = 1'b1;
        step("reset_0");
        randomize_inputs();
        reset = 1'b1;
        step("reset_1");

        idle();
        set_op(4'd3, 5'd1, 32'h0000_0005, 5'd2, 32'hFFFF_FFFD); step("add_wrap");
        set_op(4'd10, 5'd1, 32'h0000_0005, 5'd2, 32'hFFFF_FFFD); step("sub");
        set_op(4'd4, 5'd1, 32'h0000_0005, 5'd2, 32'hFFFF_FFFD); step("slt_signed");
        set_op(4'd2, 5'd1, 32'h0000_0005, 5'd2, 32'hFFFF_FFFD); shamt = 5'd1; step("sra_1");
        shamt = 5'd0; alusrc = 1'b1; imm_ext = 32'h0000_1234;
        set_op(4'd9, 5'd1, 32'h0, 5'd2, 32'h0); step("lui");
        alusrc = 1'b0;

        set_op(4'd3, 5'd1, 32'h8, 5'd2, 32'h8); rd_dest = 5'd3; regwrite = 1'b1;
        step("fwd_producer");
        set_op(4'd3, 5'd3, 32'h0, 5'd3, 32'h0); rd_dest = 5'd4;
        wb_regwrite = 1'b1; wb_rd = 5'd3; wb_data = 32'h99;
        step("fwd_exmem_wins");
        step("fwd_memwb_only");

        wb_regwrite = 1'b0;
        set_op(4'd3, 5'd1, 32'h7, 5'd2, 32'h9); rd_dest = 5'd0; step("r0_producer");
        set_op(4'd3, 5'd0, 32'h0, 5'd0, 32'h0); wb_regwrite = 1'b1; wb_rd = 5'd0;
        wb_data = 32'h55; step("r0_no_fwd");

        idle();
        set_op(4'd7, 5'd1, 32'hA5A5_0F0F, 5'd2, 32'h1234_5678); regwrite = 1'b1; step("pre_stall");
        for (int i = 0; i < 3; i++) begin
            stall = 1'b1;
            set_op(4'($urandom_range(0, 10)), 5'd1, $urandom, 5'd2, $urandom);
            step("stall_hold");
        end
        flush = 1'b1; step("flush_and_stall");
        flush = 1'b0; stall = 1'b0; step("post_flush");
        stall = 1'b1; reset = 1'b1; step("reset_in_stall");
        idle();
        set_op(4'd15, 5'd1, 32'hDEAD_BEEF, 5'd2, 32'h1); step("undef_code");

        for (int i = 0; i < 400; i++) begin
            randomize_inputs();
            step("random");
        end

        idle();
        repeat (3) @(posedge clk);
        #2;
        checks++;
        if (exp_q.size() != 0) begin
            failures++;
            $display("FAIL drain: %0d expected outputs never compared, expected 0", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
